// File: rtl/hba_master_ctrl.sv
// HBA bus initiator: turns read/write burst commands into request/grant,
// select/xferack handshakes, with a one-entry read buffer and an ack timeout.
module hba_master_ctrl #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_valid,
    input  logic [DBUS_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DBUS_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    output logic                  hba_mrequest,
    input  logic                  hba_mgrant,
    output logic                  hba_select,
    output logic                  hba_rnw,
    output logic [ADDR_WIDTH-1:0] hba_abus_master,
    output logic [DBUS_WIDTH-1:0] hba_dbus_master,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    input  logic                  hba_xferack
);

    typedef enum logic [2:0] {IDLE, REQ, SETUP, XFER, GAP, FIN} state_t;

    state_t                  state, state_nxt;
    logic                    rnw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              beats_q;
    logic [DBUS_WIDTH-1:0]   wdata_q;
    logic [15:0]             tmo_cnt;
    logic                    err_q;
    logic                    tmo_hit;
    logic                    setup_ok;

    // Counter runs 0..TIMEOUT_CYCLES-1, so select is held exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit  = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign setup_ok = hba_mgrant && (rnw_q ? !rd_valid : wr_valid);

    always_ff @(posedge hba_clk) begin
        if (hba_reset) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_valid)  state_nxt = REQ;
            REQ:   if (hba_mgrant) state_nxt = SETUP;
            SETUP: if (setup_ok)   state_nxt = XFER;
            XFER: begin
                if (hba_xferack)  state_nxt = GAP;
                else if (tmo_hit) state_nxt = FIN;
            end
            GAP:   state_nxt = (beats_q == 8'd0) ? FIN : SETUP;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        hba_mrequest    = 1'b0;
        hba_select      = 1'b0;
        hba_rnw         = 1'b0;
        hba_abus_master = '0;
        hba_dbus_master = '0;
        case (state)
            IDLE:  cmd_ready = !hba_reset;
            REQ:   hba_mrequest = 1'b1;
            SETUP: begin
                hba_mrequest = 1'b1;
                wr_ready     = !rnw_q && hba_mgrant && wr_valid;
            end
            XFER: begin
                hba_mrequest    = 1'b1;
                hba_select      = 1'b1;
                hba_rnw         = rnw_q;
                hba_abus_master = addr_q;
                hba_dbus_master = rnw_q ? '0 : wdata_q;
            end
            GAP:   hba_mrequest = 1'b1;
            FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            beats_q <= 8'd0;
            wdata_q <= '0;
            tmo_cnt <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    rnw_q   <= cmd_rnw;
                    addr_q  <= cmd_addr;
                    beats_q <= cmd_len;
                    err_q   <= 1'b0;
                end
                SETUP: begin
                    tmo_cnt <= 16'd0;
                    if (wr_ready) wdata_q <= wr_data;
                end
                XFER: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (!hba_xferack && tmo_hit) err_q <= 1'b1;
                end
                GAP: if (beats_q != 8'd0) begin
                    beats_q <= beats_q - 8'd1;
                    // Only the register field advances; the peripheral select is fixed.
                    addr_q  <= {addr_q[ADDR_WIDTH-1:REG_ADDR_WIDTH],
                                addr_q[REG_ADDR_WIDTH-1:0] + REG_ADDR_WIDTH'(1)};
                end
                default: ;
            endcase
        end
    end

    // Read buffer: XFER only starts a read while it is empty, so capture never collides.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (state == XFER && rnw_q && hba_xferack) begin
            rd_valid <= 1'b1;
            rd_data  <= hba_dbus;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hba_master_ctrl.sv
// Directed bench for hba_master_ctrl: behavioural slave, write feeder, read sink,
// and a scoreboard of expected bus transfers and read beats.
module tb_hba_master_ctrl;

    typedef struct packed {
        logic [11:0] addr;
        logic        rnw;
        logic [7:0]  data;
    } xfer_t;

    logic        hba_clk = 1'b0;
    logic        hba_reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready = 1'b0;
    logic        done, err;
    logic        hba_mrequest;
    logic        hba_mgrant = 1'b0;
    logic        hba_select, hba_rnw;
    logic [11:0] hba_abus_master;
    logic [7:0]  hba_dbus_master;
    logic [7:0]  hba_dbus;
    logic        hba_xferack;

    hba_master_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .hba_clk(hba_clk), .hba_reset(hba_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .done(done), .err(err),
        .hba_mrequest(hba_mrequest), .hba_mgrant(hba_mgrant),
        .hba_select(hba_select), .hba_rnw(hba_rnw),
        .hba_abus_master(hba_abus_master), .hba_dbus_master(hba_dbus_master),
        .hba_dbus(hba_dbus), .hba_xferack(hba_xferack)
    );

    always #5 hba_clk = ~hba_clk;

    int    n_cmp = 0, n_mis = 0;
    int    cyc = 0, acc_cyc = 0;
    int    sel_cycles = 0, wr_pulses = 0;
    int    rd_delay = 0, rd_wait = 0;
    int    wr_gap = 0, wr_gap_cnt = 0;
    int    ack_at = 2;
    logic  ack_en = 1'b1;
    logic  mon_en = 1'b0;
    logic  took = 1'b0;
    logic [7:0] sel_cnt = '0;
    logic [7:0] smem [256];
    logic [7:0] wq [$];
    logic [7:0] rd_q [$];
    xfer_t      exp_q [$];

    always @(posedge hba_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: acks on the ack_at-th consecutive select cycle, read data from smem
    always @(posedge hba_clk) sel_cnt <= hba_select ? sel_cnt + 8'd1 : 8'd0;
    assign hba_xferack = ack_en && hba_select && (sel_cnt == 8'(ack_at - 1));
    assign hba_dbus    = (hba_xferack && hba_rnw) ? smem[hba_abus_master[7:0]] : 8'h00;

    // Write feeder: holds wr_valid/wr_data stable across the accepting edge
    always begin
        @(negedge hba_clk);
        took = wr_valid && wr_ready;
        @(posedge hba_clk);
        #1;
        if (took && wq.size() > 0) begin
            wq.delete(0);
            wr_gap_cnt = wr_gap;
        end else if (wr_gap_cnt > 0) begin
            wr_gap_cnt--;
        end
        wr_valid = (wq.size() > 0) && (wr_gap_cnt == 0);
        wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    end

    // Read sink: waits rd_delay cycles per held beat, checks it, then consumes it
    always @(negedge hba_clk) begin
        if (rd_ready) begin
            rd_ready = 1'b0;
        end else if (rd_valid && mon_en) begin
            if (rd_wait < rd_delay) begin
                rd_wait++;
            end else begin
                rd_wait = 0;
                check("rd_beat_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
                rd_ready = 1'b1;
            end
        end
    end

    // Bus monitor: OR-bus rules every cycle, scoreboard on every acked transfer
    always @(negedge hba_clk) begin
        if (mon_en) begin
            xfer_t x;
            if (!hba_select) check("abus_zero_unselected", 32'(hba_abus_master), 32'd0);
            if (!(hba_select && !hba_rnw)) check("dbus_or_rule", 32'(hba_dbus_master), 32'd0);
            if (hba_select && hba_rnw) check("read_sel_buf_free", 32'(rd_valid), 32'd0);
            if (hba_select) sel_cycles++;
            if (wr_ready) wr_pulses++;
            if (hba_select && hba_xferack) begin
                check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check("xfer_addr", 32'(hba_abus_master), 32'(x.addr));
                    check("xfer_rnw", 32'(hba_rnw), 32'(x.rnw));
                    if (!x.rnw) check("xfer_wdata", 32'(hba_dbus_master), 32'(x.data));
                end
            end
        end
    end

    task automatic send_cmd(input logic rnw, input logic [11:0] addr, input logic [7:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_len   = len;
        while (!cmd_ready && n < 50) begin
            @(negedge hba_clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;
        @(negedge hba_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic derr,
                             output logic dreq);
        int n = 0;
        dcyc = -1;
        derr = 1'bx;
        dreq = 1'bx;
        while (n < budget) begin
            @(negedge hba_clk);
            n++;
            if (done) begin
                dcyc = cyc;
                derr = err;
                dreq = hba_mrequest;
                break;
            end
        end
        check("done_seen", 32'(dcyc != -1), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({cmd_ready, wr_ready, rd_valid, done, err,
                                   hba_mrequest, hba_select, hba_rnw}), 32'd0);
        check({tag, "_bus"}, 32'({rd_data, hba_abus_master, hba_dbus_master}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc;
        logic de, dr;
        int   rises;
        logic prev_sel;
        for (int i = 0; i < 256; i++) smem[i] = 8'(i) ^ 8'h5A;
        smem[8'hFE] = 8'h10;
        smem[8'hFF] = 8'h11;
        smem[8'h00] = 8'h12;
        smem[8'h01] = 8'h13;

        // Reset state
        repeat (3) @(negedge hba_clk);
        mon_en = 1'b1;
        check_all_zero("reset");
        hba_reset = 1'b0;
        @(negedge hba_clk);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // Single write, minimum latency
        hba_mgrant = 1'b1;
        wq.push_back(8'hA5);
        exp_q.push_back('{addr: 12'h203, rnw: 1'b0, data: 8'hA5});
        repeat (2) @(negedge hba_clk);
        wr_pulses = 0;
        sel_cycles = 0;
        send_cmd(1'b0, 12'h203, 8'd0);
        wait_done(20, dc, de, dr);
        check("wr1_done_latency", 32'(dc - acc_cyc), 32'd6);
        check("wr1_err", 32'(de), 32'd0);
        check("wr1_wr_ready_pulses", 32'(wr_pulses), 32'd1);
        check("wr1_select_cycles", 32'(sel_cycles), 32'd2);
        @(negedge hba_clk);
        check("wr1_done_one_cycle", 32'(done), 32'd0);
        check("wr1_cmd_ready_idle", 32'(cmd_ready), 32'd1);

        // Read burst across the register-field wrap, slow consumer
        rd_delay = 5;
        exp_q.push_back('{addr: 12'h1FE, rnw: 1'b1, data: 8'h00});
        exp_q.push_back('{addr: 12'h1FF, rnw: 1'b1, data: 8'h00});
        exp_q.push_back('{addr: 12'h100, rnw: 1'b1, data: 8'h00});
        exp_q.push_back('{addr: 12'h101, rnw: 1'b1, data: 8'h00});
        rd_q.push_back(8'h10);
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h12);
        rd_q.push_back(8'h13);
        send_cmd(1'b1, 12'h1FE, 8'd3);
        wait_done(200, dc, de, dr);
        check("rd_err", 32'(de), 32'd0);
        for (int n = 0; n < 30 && (rd_q.size() > 0 || rd_valid); n++) @(negedge hba_clk);
        check("rd_all_beats_consumed", 32'(rd_q.size()), 32'd0);
        check("rd_all_xfers_seen", 32'(exp_q.size()), 32'd0);
        rd_delay = 0;

        // Arbitration: grant withheld for 20 cycles
        hba_mgrant = 1'b0;
        wq.push_back(8'h3C);
        exp_q.push_back('{addr: 12'h512, rnw: 1'b0, data: 8'h3C});
        repeat (2) @(negedge hba_clk);
        send_cmd(1'b0, 12'h512, 8'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge hba_clk);
            check("arb_mrequest_held", 32'(hba_mrequest), 32'd1);
            check("arb_select_low", 32'(hba_select), 32'd0);
        end
        hba_mgrant = 1'b1;
        wait_done(20, dc, de, dr);
        check("arb_mrequest_drop_on_done", 32'(dr), 32'd0);
        check("arb_err", 32'(de), 32'd0);
        check("arb_xfer_seen", 32'(exp_q.size()), 32'd0);

        // Timeout: no slave ack on a 3-beat write
        ack_en = 1'b0;
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        wq.push_back(8'h33);
        repeat (2) @(negedge hba_clk);
        wr_pulses = 0;
        sel_cycles = 0;
        send_cmd(1'b0, 12'h0A0, 8'd2);
        wait_done(50, dc, de, dr);
        check("tmo_err", 32'(de), 32'd1);
        check("tmo_select_cycles", 32'(sel_cycles), 32'd8);
        check("tmo_wr_ready_pulses", 32'(wr_pulses), 32'd1);
        @(negedge hba_clk);
        check("tmo_dbus_after", 32'(hba_dbus_master), 32'd0);
        check("tmo_mrequest_after", 32'(hba_mrequest), 32'd0);
        wq.delete();
        ack_en = 1'b1;
        repeat (2) @(negedge hba_clk);

        // Write throttling with 4-cycle data gap, address wrap 0x3FF -> 0x300
        wr_gap = 4;
        wq.push_back(8'h5A);
        wq.push_back(8'hC3);
        exp_q.push_back('{addr: 12'h3FF, rnw: 1'b0, data: 8'h5A});
        exp_q.push_back('{addr: 12'h300, rnw: 1'b0, data: 8'hC3});
        repeat (2) @(negedge hba_clk);
        wr_pulses = 0;
        sel_cycles = 0;
        send_cmd(1'b0, 12'h3FF, 8'd1);
        wait_done(60, dc, de, dr);
        check("thr_wr_ready_pulses", 32'(wr_pulses), 32'd2);
        check("thr_select_cycles", 32'(sel_cycles), 32'd4);
        check("thr_err", 32'(de), 32'd0);
        check("thr_xfers_seen", 32'(exp_q.size()), 32'd0);
        wr_gap = 0;

        // Reset during the first select cycle of beat 2 of 4
        wq.push_back(8'h81);
        wq.push_back(8'h82);
        wq.push_back(8'h83);
        wq.push_back(8'h84);
        exp_q.push_back('{addr: 12'h640, rnw: 1'b0, data: 8'h81});
        repeat (2) @(negedge hba_clk);
        send_cmd(1'b0, 12'h640, 8'd3);
        rises = 0;
        prev_sel = 1'b0;
        for (int n = 0; n < 40 && rises < 2; n++) begin
            @(negedge hba_clk);
            if (hba_select && !prev_sel) rises++;
            prev_sel = hba_select;
        end
        check("rst_beat2_reached", 32'(rises), 32'd2);
        hba_reset = 1'b1;
        @(negedge hba_clk);
        check_all_zero("midrst");
        hba_reset = 1'b0;
        wq.delete();
        @(negedge hba_clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int n = 0; n < 5; n++) begin
            @(negedge hba_clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end

        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
